// File: rtl/regfile_wb_queue.sv
// Writeback queue owning the regfile write port: buffers results, drains one
// per cycle through a registered output stage, and offers newest-value bypass.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          ctrl_reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_reg,
  input  logic [31:0]   in_data,
  input  logic          wb_hold,
  output logic          ctrl_writeEnable,
  output logic [4:0]    ctrl_writeReg,
  output logic [31:0]   data_writeReg,
  input  logic [4:0]    lookup_regA,
  input  logic [4:0]    lookup_regB,
  output logic          byp_hitA,
  output logic          byp_hitB,
  output logic [31:0]   byp_dataA,
  output logic [31:0]   byp_dataB,
  output logic [AW:0]   occupancy
);

  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          push;
  logic          store;
  logic          pop;
  logic [AW-1:0] idx;

  assign in_ready  = (count != (AW+1)'(DEPTH)) && ctrl_reset_n;
  assign push      = in_valid && in_ready;
  assign store     = push && (in_reg != 5'd0);
  assign pop       = (count != '0) && !wb_hold;
  assign occupancy = count;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regMem[i]  <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      if (pop) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= regMem[head];
        data_writeReg    <= dataMem[head];
        head             <= head + AW'(1);
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
      if (store) begin
        regMem[tail]  <= in_reg;
        dataMem[tail] <= in_data;
        tail          <= tail + AW'(1);
      end
      if (store && !pop)
        count <= count + (AW+1)'(1);
      else if (!store && pop)
        count <= count - (AW+1)'(1);
    end
  end

  // Output stage is the lowest priority; FIFO entries are then scanned oldest
  // to newest so each later match overrides, leaving the newest value.
  always_comb begin
    idx       = '0;
    byp_hitA  = ctrl_writeEnable && (lookup_regA != 5'd0) && (ctrl_writeReg == lookup_regA);
    byp_hitB  = ctrl_writeEnable && (lookup_regB != 5'd0) && (ctrl_writeReg == lookup_regB);
    byp_dataA = byp_hitA ? data_writeReg : '0;
    byp_dataB = byp_hitB ? data_writeReg : '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < count) begin
        if ((lookup_regA != 5'd0) && (regMem[idx] == lookup_regA)) begin
          byp_hitA  = 1'b1;
          byp_dataA = dataMem[idx];
        end
        if ((lookup_regB != 5'd0) && (regMem[idx] == lookup_regB)) begin
          byp_hitB  = 1'b1;
          byp_dataB = dataMem[idx];
        end
      end
    end
  end

endmodule
